// File: rtl/fifo_uart_tx.sv
// Purpose : drains bytes from a registered-flag FIFO and serialises them as
//           8N1 UART frames (8E1 when UART_TX_PARITY_EN is defined).
// Latency : tx falls 2 cycles after the fifo_rd_en cycle; frame = 10 (11) bits.
// Backpress: one read per frame; fifo_empty is only looked at while idle.
// Ports   : clk, rst (async, active high), fifo_empty/fifo_data (FIFO side),
//           fifo_rd_en (read pulse), tx (serial, idle high), busy, frame_done.
// Config  : define UART_TX_PARITY_EN to add an even-parity bit after bit 7.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd5;
`endif
    localparam logic [2:0] S_STOP   = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [2:0]    bit_q,   bit_d;
    logic [7:0]    shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif
    logic          bit_end;

    // Counter restarts at every bit boundary, so each bit is exactly
    // CLKS_PER_BIT cycles with no accumulated drift.
    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Read data is valid now, one cycle after the read strobe.
                shift_d  = fifo_data;
`ifdef UART_TX_PARITY_EN
                parity_d = ^fifo_data;
`endif
                cnt_d    = '0;
                bit_d    = '0;
                state_d  = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Outputs decode only registered state, so reset reaches them at once
    // and no input has a combinational path to them.
    always_comb begin
        tx = 1'b1;
        case (state_q)
            S_START:  tx = 1'b0;
            S_DATA:   tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx = parity_q;
`endif
            default:  tx = 1'b1;
        endcase
    end

    assign fifo_rd_en = (state_q == S_FETCH);
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_STOP) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Purpose : random and directed stimulus for fifo_uart_tx against a line-level
//           UART frame model and a queue-based FIFO model.
// Latency : n/a (testbench).
// Backpress: FIFO model honours one read per fifo_rd_en pulse.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME_BUSY = 2 + NB * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data  = 8'h00;
    logic       fifo_rd_en, tx, busy, frame_done;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- FIFO model ----------------
    logic [7:0] fq[$];
    logic [7:0] pop_log[$];
    logic       push_vld = 1'b0;
    logic [7:0] push_dat = 8'h00;
    logic       glitch_en = 1'b0;

    always @(posedge clk) begin
        logic [7:0] b;
        if (push_vld) fq.push_back(push_dat);
        if (fifo_rd_en && fq.size() > 0) begin
            b = fq.pop_front();
            fifo_data <= b;
            pop_log.push_back(b);
        end
        fifo_empty <= (fq.size() == 0) ^ (glitch_en && ($urandom_range(0, 1) == 1));
    end

    task automatic push_byte(input logic [7:0] b);
        push_dat = b;
        push_vld = 1'b1;
        @(negedge clk);
        push_vld = 1'b0;
    endtask

    // ---------------- line monitor / frame model ----------------
    int         cyc = 0, rd_cyc = -100, rd_count = 0, frames = 0;
    int         busy_run = 0, last_busy = 0, gap_cnt = 0, pop_idx = 0;
    int         gap_log[$];
    logic [7:0] tx_log[$];
    logic       gap_valid = 1'b0;
    logic       in_frame = 1'b0, ok = 1'b1, exp_fd;
    int         bi = 0, k = 0;
    logic [7:0] cur = 8'h00, last_byte = 8'h00;
    logic       bitsv [0:10];

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("reset_outputs", {28'd0, tx, busy, fifo_rd_en, frame_done}, 32'h8);
            in_frame  = 1'b0;
            busy_run  = 0;
            gap_valid = 1'b0;
            pop_idx   = pop_log.size();
        end else begin
            if (fifo_rd_en) begin
                chk("rd_en_while_sending", {31'd0, in_frame}, 32'd0);
                rd_cyc = cyc;
                rd_count++;
            end
            if (busy) busy_run++;
            else if (busy_run != 0) begin
                last_busy = busy_run;
                busy_run  = 0;
            end
            if (!in_frame && tx == 1'b0) begin
                chk("start_latency", cyc - rd_cyc, 32'd2);
                if (gap_valid) gap_log.push_back(gap_cnt);
                gap_valid = 1'b0;
                if (pop_idx < pop_log.size()) begin
                    cur = pop_log[pop_idx];
                    pop_idx++;
                end else begin
                    chk("start_without_read", 32'd0, 32'd1);
                    cur = 8'h00;
                end
                bitsv[0] = 1'b0;
                for (int i = 0; i < 8; i++) bitsv[i+1] = cur[i];
                if (NB == 11) bitsv[9] = ^cur;
                bitsv[NB-1] = 1'b1;
                in_frame = 1'b1;
                bi = 0;
                k  = 0;
                ok = 1'b1;
            end
            if (in_frame) begin
                if (tx !== bitsv[bi] || busy !== 1'b1) ok = 1'b0;
                exp_fd = (bi == NB - 1) && (k == CPB - 1);
                if (frame_done || exp_fd) chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
                k++;
                if (k == CPB) begin
                    chk($sformatf("bit%0d_of_%02h", bi, cur), {31'd0, ok}, 32'd1);
                    ok = 1'b1;
                    k  = 0;
                    bi++;
                    if (bi == NB) begin
                        in_frame  = 1'b0;
                        frames++;
                        last_byte = cur;
                        tx_log.push_back(cur);
                        gap_cnt   = 0;
                        gap_valid = 1'b1;
                    end
                end
            end else begin
                if (frame_done) chk("stray_frame_done", 32'd1, 32'd0);
                if (tx) gap_cnt++;
            end
        end
    end

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget && frames < target; i++) @(negedge clk);
        chk("frames_timeout", {31'd0, frames >= target}, 32'd1);
    endtask

    task automatic wait_bit(input int idx, input int budget);
        int i;
        i = 0;
        while (!(in_frame && bi == idx) && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("wait_bit_timeout", {31'd0, i < budget}, 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, fb, g0, ti;
        logic bad_rd, bad_tx, bad_busy;
        logic [7:0] pushed[$];

        // reset, then first byte with FIFO already non-empty at release
        rst = 1'b1;
        repeat (2) @(negedge clk);
        push_byte(8'hA5);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rd_en_after_reset", {31'd0, fifo_rd_en}, 32'd1);
        wait_frames(1, 200);
        repeat (3) @(negedge clk);
        chk("busy_cycles_A5", last_busy, FRAME_BUSY);
        chk("byte_A5", {24'd0, last_byte}, 32'hA5);
        chk("rd_count_A5", rd_count, 32'd1);

        // back-to-back frames
        base = rd_count;
        fb   = frames;
        g0   = gap_log.size();
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        wait_frames(fb + 3, 400);
        repeat (3) @(negedge clk);
        chk("rd_count_b2b", rd_count - base, 32'd3);
        chk("gap_count", gap_log.size(), g0 + 3);
        if (gap_log.size() >= g0 + 3) begin
            chk("gap_1_2", gap_log[g0+1], 32'd3);
            chk("gap_2_3", gap_log[g0+2], 32'd3);
        end
        chk("last_b2b", {24'd0, last_byte}, 32'h03);
        chk("fifo_drained", {30'd0, fifo_empty, fq.size() == 0}, 32'd3);

        // empty FIFO for 100 cycles
        bad_rd = 1'b0; bad_tx = 1'b0; bad_busy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bad_rd   |= fifo_rd_en;
            bad_tx   |= ~tx;
            bad_busy |= busy;
        end
        chk("idle_rd_en", {31'd0, bad_rd}, 32'd0);
        chk("idle_tx_low", {31'd0, bad_tx}, 32'd0);
        chk("idle_busy", {31'd0, bad_busy}, 32'd0);

        // parity-sensitive bytes
        fb = frames;
        push_byte(8'h07);
        push_byte(8'h03);
        wait_frames(fb + 2, 300);
        repeat (3) @(negedge clk);
        chk("busy_cycles_07_03", last_busy, FRAME_BUSY);
        chk("last_03", {24'd0, last_byte}, 32'h03);

        // reset in the middle of data bit 3 of 0x55
        fb = frames;
        push_byte(8'h55);
        push_byte(8'h3C);
        wait_bit(4, 200);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("async_reset_tx_busy", {30'd0, tx, busy}, 32'd2);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        wait_frames(fb + 1, 200);
        repeat (60) @(negedge clk);
        chk("frames_after_reset", frames, fb + 1);
        chk("byte_after_reset", {24'd0, last_byte}, 32'h3C);
        chk("fifo_after_reset", fq.size(), 32'd0);

        // fifo_empty toggling during a frame
        base = rd_count;
        fb   = frames;
        push_byte(8'h96);
        wait_bit(0, 100);
        glitch_en = 1'b1;
        wait_bit(NB - 1, 200);
        glitch_en = 1'b0;
        wait_frames(fb + 1, 100);
        repeat (30) @(negedge clk);
        chk("rd_count_glitch", rd_count - base, 32'd1);
        chk("byte_glitch", {24'd0, last_byte}, 32'h96);

        // random bytes at random spacing
        fb = frames;
        ti = tx_log.size();
        for (int i = 0; i < 12; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            pushed.push_back(b);
            push_byte(b);
            repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        wait_frames(fb + 12, 1500);
        repeat (10) @(negedge clk);
        chk("random_frames", frames - fb, 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (ti + i < tx_log.size())
                chk($sformatf("random_order_%0d", i), {24'd0, tx_log[ti+i]}, {24'd0, pushed[i]});
            else
                chk($sformatf("random_missing_%0d", i), 32'd0, 32'd1);
        end
        chk("random_fifo_empty", fq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
